// File: rtl/silpa_spi_master.sv
// -----------------------------------------------------------------------------
// silpa_spi_master
//
// SPI initiator for the silpa_fpga register interface. Each accepted command
// becomes one frame of ADDR_W address bits followed by DATA_W data bits, MSB
// first. The bits shifted in on spi_miso during the frame are returned as a
// response (the slave echoes the previous frame's address and data).
//
// Wire timing: spi_clk idles low. MOSI is launched while spi_clk is low and
// MISO is sampled on the sys_clk edge that drops spi_clk. spi_cs is high for
// (2N+1)*HALF_DIV sys_clk cycles per frame. At least GAP_CYCLES+1 spi_cs-low
// cycles separate consecutive frames.
//
// Parameters:
//   ADDR_W     address field width
//   DATA_W     data field width
//   HALF_DIV   sys_clk cycles per spi_clk half period (>= 1)
//   GAP_CYCLES minimum spi_cs-low cycles between frames (>= 1)
//
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_addr, cmd_data   frame contents
//   rsp_valid            one-cycle pulse when rsp_addr/rsp_data update
//   rsp_addr, rsp_data   MISO bits of the last completed frame
//   busy                 frame or inter-frame gap in progress
//   spi_clk, spi_mosi, spi_miso, spi_cs   SPI bus (spi_cs active-high)
//
// State table:
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready high
//   LOW    | spi_clk low half period, MOSI bit stable
//   HIGH   | spi_clk high half period, MISO sampled as it ends
//   TAIL   | trailing low half period before spi_cs drops
//   GAP    | spi_cs low guard time before the next frame
// -----------------------------------------------------------------------------
module silpa_spi_master #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 16,
   parameter int HALF_DIV   = 1,
   parameter int GAP_CYCLES = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              spi_cs
);

   localparam int N       = ADDR_W + DATA_W;
   localparam int CNT_MAX = (HALF_DIV > GAP_CYCLES) ? HALF_DIV : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(N);

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(N - 1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOW  = 3'd1,
      S_HIGH = 3'd2,
      S_TAIL = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [CNT_W-1:0]  phase_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              phase_tc;
   logic              bit_tc;

   logic [N-1:0]      cmd_word;
   // Holds the bits still to be sent after the one currently on spi_mosi.
   logic [N-2:0]      tx_sr;
   logic [N-1:0]      rx_sr;

   logic              accept;
   logic              clk_rise;
   logic              clk_fall;
   logic              frame_done;
   logic              phase_load;
   logic [CNT_W-1:0]  phase_load_val;

   assign cmd_word = {cmd_addr, cmd_data};
   assign phase_tc = (phase_cnt == '0);
   assign bit_tc   = (bit_cnt == '0);

   // ---------------------------------------------------------------- state
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (cmd_valid && cmd_ready) next_state = S_LOW;
         S_LOW:  if (phase_tc) next_state = S_HIGH;
         S_HIGH: if (phase_tc) next_state = bit_tc ? S_TAIL : S_LOW;
         S_TAIL: if (phase_tc) next_state = S_GAP;
         S_GAP:  if (phase_tc) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      busy       = (state != S_IDLE);
      accept     = (state == S_IDLE) && cmd_valid && cmd_ready;
      clk_rise   = (state == S_LOW)  && phase_tc;
      clk_fall   = (state == S_HIGH) && phase_tc;
      frame_done = (state == S_TAIL) && phase_tc;
      // Every state change restarts the phase timer for the state entered.
      phase_load     = (next_state != state);
      phase_load_val = (next_state == S_GAP) ? GAP_LOAD : HALF_LOAD;
   end

   // --------------------------------------------------------------- timers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         phase_cnt <= '0;
      end else if (phase_load) begin
         phase_cnt <= phase_load_val;
      end else if (!phase_tc) begin
         phase_cnt <= phase_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         bit_cnt <= '0;
      end else if (accept) begin
         bit_cnt <= BIT_LOAD;
      end else if (clk_fall && !bit_tc) begin
         bit_cnt <= bit_cnt - BIT_ONE;
      end
   end

   // -------------------------------------------------- handshake / response
   // cmd_ready is registered so it stays low throughout reset and rises on
   // the first edge after release.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_addr  <= '0;
         rsp_data  <= '0;
      end else begin
         cmd_ready <= (next_state == S_IDLE);
         rsp_valid <= frame_done;
         if (frame_done) begin
            rsp_addr <= rx_sr[N-1:DATA_W];
            rsp_data <= rx_sr[DATA_W-1:0];
         end
      end
   end

   // -------------------------------------------------------------- SPI bus
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         spi_cs   <= 1'b0;
         spi_clk  <= 1'b0;
         spi_mosi <= 1'b0;
         tx_sr    <= '0;
      end else begin
         if (accept) begin
            spi_cs   <= 1'b1;
            spi_mosi <= cmd_word[N-1];
            tx_sr    <= cmd_word[N-2:0];
         end
         if (clk_rise) begin
            spi_clk <= 1'b1;
         end
         if (clk_fall) begin
            spi_clk <= 1'b0;
            // The last bit stays on the wire through TAIL; no further shift.
            if (!bit_tc) begin
               spi_mosi <= tx_sr[N-2];
               tx_sr    <= tx_sr << 1;
            end
         end
         if (frame_done) begin
            spi_cs   <= 1'b0;
            spi_mosi <= 1'b0;
         end
      end
   end

   // MISO is taken on the edge that ends the high phase, i.e. the value the
   // slave presented while spi_clk was high.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_sr <= '0;
      end else if (clk_fall) begin
         rx_sr <= {rx_sr[N-2:0], spi_miso};
      end
   end

endmodule

// File: tb/tb_silpa_spi_master.sv
module tb_silpa_spi_master;

   localparam int AW  = 6;
   localparam int DW  = 16;
   localparam int N   = AW + DW;
   localparam int GAP = 2;
   localparam int H   = 1;
   localparam int H3  = 3;
   localparam int T   = (2 * N + 1) * H;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b1;
   always #5 sys_clk = ~sys_clk;

   // main instance (HALF_DIV=1)
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          rsp_valid;
   logic [AW-1:0] rsp_addr;
   logic [DW-1:0] rsp_data;
   logic          busy;
   logic          spi_clk, spi_mosi, spi_miso, spi_cs;

   // second instance (HALF_DIV=3), MISO looped back
   logic          cmd_valid3 = 1'b0;
   logic          cmd_ready3;
   logic [AW-1:0] cmd_addr3 = '0;
   logic [DW-1:0] cmd_data3 = '0;
   logic          rsp_valid3;
   logic [AW-1:0] rsp_addr3;
   logic [DW-1:0] rsp_data3;
   logic          busy3;
   logic          spi_clk3, spi_mosi3, spi_miso3, spi_cs3;

   silpa_spi_master #(.ADDR_W(AW), .DATA_W(DW), .HALF_DIV(H), .GAP_CYCLES(GAP)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .busy(busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_cs(spi_cs));

   silpa_spi_master #(.ADDR_W(AW), .DATA_W(DW), .HALF_DIV(H3), .GAP_CYCLES(GAP)) dut3 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_addr(cmd_addr3), .cmd_data(cmd_data3),
      .rsp_valid(rsp_valid3), .rsp_addr(rsp_addr3), .rsp_data(rsp_data3),
      .busy(busy3), .spi_clk(spi_clk3), .spi_mosi(spi_mosi3),
      .spi_miso(spi_miso3), .spi_cs(spi_cs3));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ MISO source
   // 0 = random bits, 1 = loopback of MOSI, 2 = slave echoing previous frame
   int   miso_mode = 0;
   logic rnd_miso  = 1'b0;
   logic slave_bit;
   assign spi_miso  = (miso_mode == 0) ? rnd_miso : (miso_mode == 1) ? spi_mosi : slave_bit;
   assign spi_miso3 = spi_mosi3;

   always @(posedge sys_clk) begin
      #1;
      rnd_miso = 1'($urandom_range(0, 1));
   end

   logic [N-1:0] slv_in   = '0;
   logic [N-1:0] slv_prev = '0;
   logic [N-1:0] slv_out  = '0;
   int           slv_idx  = 0;
   always @(posedge spi_clk) slv_in = {slv_in[N-2:0], spi_mosi};
   always @(negedge spi_clk) if (spi_cs) slv_idx++;
   always @(posedge spi_cs) begin slv_idx = 0; slv_out = slv_prev; end
   always @(negedge spi_cs) slv_prev = slv_in;
   assign slave_bit = slv_out[N - 1 - ((slv_idx < N) ? slv_idx : N - 1)];

   // ------------------------------------------------------ behavioural model
   // c counts sys_clk cycles since the accept edge (0 = idle). Everything the
   // pins must show is a pure function of c and the accepted frame.
   int           c       = 0;
   logic         m_ready = 1'b0;
   logic [N-1:0] m_frame = '0;
   logic [N-1:0] m_rx    = '0;
   logic [N-1:0] m_rsp   = '0;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         c       = 0;
         m_ready = 1'b0;
         m_rsp   = '0;
      end else begin
         if (c >= 1 && c <= 2 * N * H && ((c - 1) % (2 * H)) == 2 * H - 1)
            m_rx = {m_rx[N-2:0], spi_miso};
         if (c == T) m_rsp = m_rx;
         if (c == 0) begin
            if (m_ready && cmd_valid) begin
               m_frame = {cmd_addr, cmd_data};
               c = 1;
            end
         end else if (c == T + GAP) begin
            c = 0;
         end else begin
            c++;
         end
         m_ready = (c == 0);
      end
   end

   // -------------------------------------------- per-cycle compare + monitor
   logic         cs_prev = 1'b0, clk_prev = 1'b0;
   int           cs_len = 0, rise_cnt = 0, low_run = 0;
   int           last_cs_len = 0, last_rise = 0, last_low_run = 0, rsp_cnt = 0;
   logic [N-1:0] mosi_sr = '0, last_mosi = '0;

   always @(negedge sys_clk) begin
      logic e_cs, e_clk, e_mosi;
      int   bi;
      e_cs   = (c >= 1 && c <= T);
      e_clk  = e_cs && (c - 1) < 2 * N * H && ((c - 1) % (2 * H)) >= H;
      e_mosi = 1'b0;
      if (e_cs) begin
         bi = (c - 1) / (2 * H);
         if (bi > N - 1) bi = N - 1;
         e_mosi = m_frame[N - 1 - bi];
      end
      chk("cs", spi_cs, e_cs);
      chk("sclk", spi_clk, e_clk);
      chk("mosi", spi_mosi, e_mosi);
      chk("rsp_valid", rsp_valid, (c == T + 1));
      chk("busy", busy, (c != 0));
      chk("ready", cmd_ready, m_ready);
      chk("rsp", {rsp_addr, rsp_data}, m_rsp);

      if (spi_cs && !cs_prev) begin
         last_low_run = low_run;
         low_run = 0; cs_len = 0; rise_cnt = 0; mosi_sr = '0;
      end
      if (spi_cs) cs_len++;
      else        low_run++;
      if (spi_cs && spi_clk && !clk_prev) begin
         rise_cnt++;
         mosi_sr = {mosi_sr[N-2:0], spi_mosi};
      end
      if (!spi_cs && cs_prev) begin
         last_cs_len = cs_len; last_rise = rise_cnt; last_mosi = mosi_sr;
      end
      if (rsp_valid) rsp_cnt++;
      cs_prev  = spi_cs;
      clk_prev = spi_clk;
   end

   // monitor for the HALF_DIV=3 instance: run lengths of spi_clk inside spi_cs
   logic cs3_prev = 1'b0, clk3_prev = 1'b0, run_val = 1'b0;
   int   cs3_len = 0, last_cs3_len = 0, rise3 = 0, run_len = 0;
   int   hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;

   task automatic rec_run(input logic v, input int len);
      if (v) begin
         if (len < hi_min) hi_min = len;
         if (len > hi_max) hi_max = len;
      end else begin
         if (len < lo_min) lo_min = len;
         if (len > lo_max) lo_max = len;
      end
   endtask

   always @(negedge sys_clk) begin
      if (spi_cs3 && !cs3_prev) begin
         cs3_len = 0; rise3 = 0; run_val = spi_clk3; run_len = 0;
         hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
      end
      if (spi_cs3) begin
         cs3_len++;
         if (spi_clk3 && !clk3_prev) rise3++;
         if (spi_clk3 == run_val) run_len++;
         else begin
            rec_run(run_val, run_len);
            run_val = spi_clk3;
            run_len = 1;
         end
      end
      if (!spi_cs3 && cs3_prev) begin
         rec_run(run_val, run_len);
         last_cs3_len = cs3_len;
      end
      cs3_prev  = spi_cs3;
      clk3_prev = spi_clk3;
   end

   // --------------------------------------------------------------- stimulus
   task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
      int n;
      n = 0;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(negedge sys_clk);
      while (!cmd_ready && n < 300) begin
         @(negedge sys_clk);
         n++;
      end
      chk("accept_wait", cmd_ready, 1'b1);
      @(posedge sys_clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      chk("rsp_wait", rsp_valid, 1'b1);
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      int n;
      int rc0;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;

      // reset values
      #1 sys_rst_n = 1'b0;
      #1;
      chk("rst_cs", spi_cs, 1'b0);
      chk("rst_sclk", spi_clk, 1'b0);
      chk("rst_mosi", spi_mosi, 1'b0);
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_rsp", {rsp_valid, rsp_addr, rsp_data}, '0);
      chk("rst_busy", busy, 1'b0);
      repeat (3) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      chk("ready_after_release", cmd_ready, 1'b1);

      // 0x01/0xAAAA: frame length, edge count, bits at rising edges
      miso_mode = 0;
      send(6'h01, 16'hAAAA, 1'b0);
      wait_rsp();
      chk("t1_cs_len", last_cs_len, 45);
      chk("t1_rises", last_rise, 22);
      chk("t1_mosi_bits", last_mosi, {6'h01, 16'hAAAA});

      // loopback
      miso_mode = 1;
      send(6'h05, 16'h5555, 1'b0);
      wait_rsp();
      chk("loop_addr", rsp_addr, 6'h05);
      chk("loop_data", rsp_data, 16'h5555);

      // echoing slave
      miso_mode = 2;
      send(6'h00, 16'h2A2A, 1'b0);
      wait_rsp();
      send(6'h00, 16'h0000, 1'b0);
      wait_rsp();
      chk("echo_addr", rsp_addr, 6'h00);
      chk("echo_data", rsp_data, 16'h2A2A);

      // back-to-back with cmd_valid held
      miso_mode = 0;
      send(6'h10, 16'hFFFF, 1'b1);
      cmd_addr = 6'h00;
      cmd_data = 16'hAAAA;
      n = 0;
      @(negedge sys_clk);
      while (!cmd_ready && n < 200) begin
         n++;
         @(negedge sys_clk);
      end
      chk("held_ready_low", n, T + GAP);
      @(posedge sys_clk);
      #1 cmd_valid = 1'b0;
      wait_rsp();
      chk("held_gap", last_low_run, GAP + 1);
      chk("held_mosi_bits", last_mosi, {6'h00, 16'hAAAA});

      // randomized frames
      for (int k = 0; k < 8; k++) begin
         ra = AW'($urandom);
         rd = DW'($urandom);
         miso_mode = int'($urandom_range(0, 1));
         repeat ($urandom_range(0, 5)) @(posedge sys_clk);
         #1;
         send(ra, rd, 1'b0);
         wait_rsp();
         chk("rnd_mosi_bits", last_mosi, {ra, rd});
         chk("rnd_cs_len", last_cs_len, T);
         if (miso_mode == 1) chk("rnd_loop", {rsp_addr, rsp_data}, {ra, rd});
      end

      // HALF_DIV=3 instance
      cmd_addr3  = 6'h20;
      cmd_data3  = 16'hFFFF;
      cmd_valid3 = 1'b1;
      n = 0;
      @(negedge sys_clk);
      while (!cmd_ready3 && n < 50) begin
         @(negedge sys_clk);
         n++;
      end
      @(posedge sys_clk);
      #1 cmd_valid3 = 1'b0;
      n = 0;
      while (!rsp_valid3 && n < 600) begin
         @(negedge sys_clk);
         n++;
      end
      chk("h3_rsp_wait", rsp_valid3, 1'b1);
      @(posedge sys_clk);
      #1;
      chk("h3_cs_len", last_cs3_len, 135);
      chk("h3_rises", rise3, 22);
      chk("h3_hi_min", hi_min, 3);
      chk("h3_hi_max", hi_max, 3);
      chk("h3_lo_min", lo_min, 3);
      chk("h3_lo_max", lo_max, 3);
      chk("h3_rsp", {rsp_addr3, rsp_data3}, {6'h20, 16'hFFFF});

      // reset during bit 10 of 0x28/0xFFFF
      miso_mode = 1;
      send(6'h28, 16'hFFFF, 1'b0);
      repeat (20) @(posedge sys_clk);
      #2;
      chk("mid_cs_before", spi_cs, 1'b1);
      rc0 = rsp_cnt;
      sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_cs", spi_cs, 1'b0);
      chk("mid_rst_sclk", spi_clk, 1'b0);
      chk("mid_rst_mosi", spi_mosi, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      repeat (3) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      repeat (60) @(negedge sys_clk);
      chk("mid_no_rsp", rsp_cnt, rc0);
      #1;
      send(6'h0B, 16'h1234, 1'b0);
      wait_rsp();
      chk("post_rst_rsp", {rsp_addr, rsp_data}, {6'h0B, 16'h1234});
      chk("post_rst_cs_len", last_cs_len, 45);

      repeat (5) @(posedge sys_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/silpa_spi_master.md
Name: silpa_spi_master

Overview:
- SPI initiator for the silpa_fpga register interface. It lets a host-side controller (system board MCU bridge or on-board sequencer) issue the 6-bit-address / 16-bit-data frames that the silpa_fpga SPI slave decodes.
- Register map served by the slave: 0-7 output, 8-15 input, 16-23 direction, 32-39 interrupt mask, 40-47 interrupt clear.
- Each command produces one 22-bit frame. Shifted-in MISO bits are returned as a response: the slave echoes the previous frame's address and data.

Parameters:
- ADDR_W, 6, address field width (MSB first on the wire).
- DATA_W, 16, data field width (follows the address).
- HALF_DIV, 1, sys_clk cycles per SPI clock half-period; must be >= 1.
- GAP_CYCLES, 2, minimum sys_clk cycles with spi_cs low between frames; must be >= 1.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_addr  in  ADDR_W  frame address
- cmd_data  in  DATA_W  frame data
- rsp_valid  out  1  one-cycle pulse, response fields valid
- rsp_addr  out  ADDR_W  first ADDR_W MISO bits of the completed frame
- rsp_data  out  DATA_W  last DATA_W MISO bits of the completed frame
- busy  out  1  frame or gap in progress
- spi_clk  out  1  SPI clock, idle low
- spi_mosi  out  1  master data out
- spi_miso  in  1  slave data in
- spi_cs  out  1  frame enable, active-high (high for the whole frame)

Behaviour:
- Reset (async assert, sync release) puts outputs in these states:
  - spi_clk=0, spi_mosi=0, spi_cs=0
  - cmd_ready=0 during reset, 1 in the first cycle after release
  - rsp_valid=0, rsp_addr=0, rsp_data=0, busy=0
  - FSM=IDLE
- FSM states: IDLE, LOW, HIGH, TAIL, GAP. N=ADDR_W+DATA_W (22); bit counter 0..N-1; phase counter 0..HALF_DIV-1.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&cmd_ready: latch {cmd_addr,cmd_data} into a TX shift register, set spi_cs<=1 and spi_mosi<=bit N-1, go to LOW.
  - Inputs are ignored after the accept edge.
- LOW: spi_clk=0 for HALF_DIV cycles, then spi_clk<=1 and go to HIGH.
- HIGH: spi_clk=1 for HALF_DIV cycles. On the final cycle:
  - spi_clk<=0.
  - spi_miso is shifted into the RX register LSB-side; the value is the one present during the high phase, sampled on the same edge that drops the clock.
  - If bit counter = N-1, go to TAIL.
  - Otherwise spi_mosi<=next bit and go to LOW.
- TAIL: spi_clk=0 for HALF_DIV cycles, then:
  - spi_cs<=0, spi_mosi<=0
  - rsp_addr<=RX[N-1:DATA_W], rsp_data<=RX[DATA_W-1:0]
  - rsp_valid pulses for exactly 1 cycle
  - go to GAP.
- GAP: spi_cs low for GAP_CYCLES cycles, then IDLE. cmd_ready=0 throughout.
- Frame timing: spi_cs is high for exactly (2N+1)*HALF_DIV cycles. With defaults that is 45 cycles, with 22 rising spi_clk edges.
- MOSI changes only while spi_clk is low, and at least HALF_DIV cycles before each rising edge.
- busy=1 in all states except IDLE.
- cmd_valid held continuously: the next command is accepted in the first IDLE cycle. The spacing is exactly GAP_CYCLES+1 cycles of spi_cs low between frames.
- rsp_addr/rsp_data hold their values until the next frame completes.
- Reset mid-frame: immediate return to reset values, no rsp_valid pulse, partial RX data discarded.
- spi_miso is used as-is (synchronous slave assumed); no synchroniser inside the block.

Test Plan:
- Write addr 0x01 data 0xAAAA, HALF_DIV=1 -> spi_cs high 45 cycles, 22 spi_clk rising edges, MOSI bits sampled at rising edges = 000001 then 1010101010101010.
- Loopback spi_miso=spi_mosi with cmd 0x05/0x5555 -> rsp_valid one cycle after spi_cs falls, rsp_addr=0x05, rsp_data=0x5555.
- Behavioural slave model echoing the previous frame: send 0x00/0x2A2A then 0x00/0x0000 -> second response rsp_addr=0x00, rsp_data=0x2A2A.
- cmd_valid held high, two commands (0x10/0xFFFF, 0x00/0xAAAA) -> spi_cs low exactly GAP_CYCLES+1=3 cycles between frames; cmd_ready low from accept until IDLE.
- HALF_DIV=3, cmd 0x20/0xFFFF -> spi_clk high and low phases 3 cycles each, spi_cs high 135 cycles.
- Assert sys_rst_n low at bit 10 of frame 0x28/0xFFFF -> spi_cs, spi_clk, spi_mosi low in the same cycle, no rsp_valid; a new command after release completes normally.
